// File: rtl/traffic_phase_arbiter_if.sv
// Request inputs and light/grant outputs of the intersection phase arbiter.
interface traffic_phase_arbiter_if;
    logic [3:0] req;
    logic [3:0] emg_req;
    logic [1:0] n_light;
    logic [1:0] e_light;
    logic [1:0] s_light;
    logic [1:0] w_light;
    logic [1:0] grant_dir;
    logic       grant_valid;
    logic       emg_active;

    // Requesting side: sensors and emergency preemption drive req/emg_req.
    modport master (
        output req, emg_req,
        input  n_light, e_light, s_light, w_light, grant_dir, grant_valid, emg_active
    );

    // Arbiter side.
    modport slave (
        input  req, emg_req,
        output n_light, e_light, s_light, w_light, grant_dir, grant_valid, emg_active
    );
endinterface

// File: rtl/traffic_phase_arbiter.sv
// Demand-actuated GREEN/YELLOW/ALL_RED phase scheduler for a four-way intersection.
module traffic_phase_arbiter #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned GREEN_MIN_S   = 5,
    parameter int unsigned GREEN_MAX_S   = 15,
    parameter int unsigned YELLOW_S      = 2,
    parameter int unsigned ALL_RED_S     = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    traffic_phase_arbiter_if.slave  bus
);
    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0] GREEN_MIN = 8'(GREEN_MIN_S);
    localparam logic [7:0] GREEN_MAX = 8'(GREEN_MAX_S);
    localparam logic [7:0] YELLOW_T  = 8'(YELLOW_S);
    localparam logic [7:0] ALL_RED_T = 8'(ALL_RED_S);
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        S_ALL_RED = 2'b00,
        S_GREEN   = 2'b01,
        S_YELLOW  = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         sec_q, sec_d;
    logic [1:0]         grant_dir_q, grant_dir_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic               emg_active_q, emg_active_d;
    logic               grant_valid_q, grant_valid_d;
    logic [7:0]         lights_q, lights_d;

    logic               tick;
    logic [7:0]         sec_inc;
    logic [7:0]         elapsed;
    logic [3:0]         grant_mask;
    logic               others_pending;
    logic               emg_other;
    logic [1:0]         emg_pick;
    logic [1:0]         rr_pick;
    logic [1:0]         rr_idx;

    // Seconds elapsed in the current state, counting a tick that lands this cycle.
    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        sec_inc = (sec_q == 8'hFF) ? sec_q : sec_q + 8'd1;
        elapsed = tick ? sec_inc : sec_q;
    end

    // Demand seen on approaches other than the current grant.
    always_comb begin
        grant_mask     = 4'b0001 << grant_dir_q;
        others_pending = (((bus.req | bus.emg_req) & ~grant_mask) != 4'b0000);
        emg_other      = ((bus.emg_req & ~grant_mask) != 4'b0000);
    end

    // Emergency winner: lowest set index.
    always_comb begin
        emg_pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.emg_req[i]) emg_pick = 2'(i);
        end
    end

    // Round-robin winner: first set req starting after last_grant.
    always_comb begin
        rr_pick = 2'd0;
        rr_idx  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            rr_idx = last_grant_q + 2'd1 + 2'(k);
            if (bus.req[rr_idx]) rr_pick = rr_idx;
        end
    end

    // Next-state, grant bookkeeping, counters and registered output decode.
    always_comb begin
        state_d       = state_q;
        grant_dir_d   = grant_dir_q;
        last_grant_d  = last_grant_q;
        emg_active_d  = emg_active_q;
        presc_d       = tick ? '0 : presc_q + PRESC_W'(1);
        sec_d         = elapsed;
        lights_d      = 8'h00;
        grant_valid_d = 1'b0;

        case (state_q)
            S_ALL_RED: begin
                if (elapsed >= ALL_RED_T) begin
                    if (bus.emg_req != 4'b0000) begin
                        state_d      = S_GREEN;
                        grant_dir_d  = emg_pick;
                        last_grant_d = emg_pick;
                        emg_active_d = 1'b1;
                    end else if (bus.req != 4'b0000) begin
                        state_d      = S_GREEN;
                        grant_dir_d  = rr_pick;
                        last_grant_d = rr_pick;
                        emg_active_d = 1'b0;
                    end
                end
            end
            S_GREEN: begin
                if (bus.emg_req[grant_dir_q]) begin
                    state_d = S_GREEN;
                end else if (emg_other && !emg_active_q) begin
                    state_d = S_YELLOW;
                end else if (others_pending &&
                             ((elapsed >= GREEN_MIN && !bus.req[grant_dir_q]) ||
                              (elapsed >= GREEN_MAX))) begin
                    state_d = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (elapsed >= YELLOW_T) begin
                    state_d      = S_ALL_RED;
                    emg_active_d = 1'b0;
                end
            end
            default: begin
                state_d = S_ALL_RED;
            end
        endcase

        if (state_d != state_q) begin
            presc_d = '0;
            sec_d   = 8'd0;
        end

        if (state_d == S_GREEN) begin
            lights_d[{grant_dir_d, 1'b0} +: 2] = LIGHT_GREEN;
            grant_valid_d = 1'b1;
        end else if (state_d == S_YELLOW) begin
            lights_d[{grant_dir_d, 1'b0} +: 2] = LIGHT_YELLOW;
            grant_valid_d = 1'b1;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_ALL_RED;
            presc_q       <= '0;
            sec_q         <= 8'd0;
            grant_dir_q   <= 2'd0;
            last_grant_q  <= 2'd3;
            emg_active_q  <= 1'b0;
            grant_valid_q <= 1'b0;
            lights_q      <= 8'h00;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            sec_q         <= sec_d;
            grant_dir_q   <= grant_dir_d;
            last_grant_q  <= last_grant_d;
            emg_active_q  <= emg_active_d;
            grant_valid_q <= grant_valid_d;
            lights_q      <= lights_d;
        end
    end

    assign bus.n_light     = lights_q[1:0];
    assign bus.e_light     = lights_q[3:2];
    assign bus.s_light     = lights_q[5:4];
    assign bus.w_light     = lights_q[7:6];
    assign bus.grant_dir   = grant_dir_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.emg_active  = emg_active_q;
endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed scoreboard bench for traffic_phase_arbiter with short timing parameters.
module tb_traffic_phase_arbiter;
    localparam int unsigned TPS = 4;
    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    logic clk = 1'b0;
    logic reset_n;

    traffic_phase_arbiter_if bus();

    traffic_phase_arbiter #(
        .TICKS_PER_SEC (TPS),
        .GREEN_MIN_S   (2),
        .GREEN_MAX_S   (4),
        .YELLOW_S      (1),
        .ALL_RED_S     (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] lights;
        logic [1:0] gdir;
        logic       gvalid;
        logic       emg;
    } obs_t;

    typedef struct {
        int unsigned at;
        obs_t        val;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc   = 0;
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned r     = 0;

    function automatic obs_t mk(input logic [1:0] dir, input logic [1:0] lt, input logic emg);
        obs_t v;
        v.lights = 8'h00;
        v.lights[{dir, 1'b0} +: 2] = lt;
        v.gdir   = dir;
        v.gvalid = (lt != RED);
        v.emg    = emg;
        return v;
    endfunction

    task automatic push(input int unsigned at, input obs_t v, input string tag);
        exp_t e;
        e.at  = at;
        e.val = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Pop every expectation that is due and compare it with the DUT outputs.
    task automatic check_due();
        obs_t o;
        exp_t e;
        o = {bus.w_light, bus.s_light, bus.e_light, bus.n_light,
             bus.grant_dir, bus.grant_valid, bus.emg_active};
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e = exp_q.pop_front();
            total++;
            assert (o === e.val) else begin
                bad++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h", e.tag, e.at, o, e.val);
            end
        end
    endtask

    task automatic step(input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            @(posedge clk);
            #1;
            cyc++;
            check_due();
        end
    endtask

    // Async reset with an immediate output check, then release with given requests.
    task automatic do_reset(input logic [3:0] rq, input logic [3:0] eq, input string tag);
        reset_n     = 1'b0;
        bus.req     = 4'b0000;
        bus.emg_req = 4'b0000;
        #1;
        push(cyc, mk(2'd0, RED, 1'b0), tag);
        check_due();
        step(2);
        bus.req     = rq;
        bus.emg_req = eq;
        reset_n     = 1'b1;
        r           = cyc;
    endtask

    initial begin
        int unsigned off;
        logic [1:0]  dir;
        logic [1:0]  lt;

        // Idle: no demand keeps everything red.
        do_reset(4'b0000, 4'b0000, "reset_state");
        for (int k = 1; k <= 200; k++) push(r + k, mk(2'd0, RED, 1'b0), "idle");
        step(200);

        // Single demand on N: green after one all-red second, then held.
        do_reset(4'b0001, 4'b0000, "reset_single");
        for (int k = 1; k <= 200; k++) begin
            if (k < 4) push(r + k, mk(2'd0, RED, 1'b0), "single_allred");
            else       push(r + k, mk(2'd0, GREEN, 1'b0), "single_green");
        end
        step(200);

        // Max-out rotation N,E,S,W,N with 16/4/4 cycle phases.
        do_reset(4'b1111, 4'b0000, "reset_rot");
        for (int k = 1; k <= 115; k++) begin
            if (k < 4) begin
                push(r + k, mk(2'd0, RED, 1'b0), "rot_start");
            end else begin
                off = (k - 4) % 24;
                dir = 2'(((k - 4) / 24) % 4);
                lt  = (off < 16) ? GREEN : ((off < 20) ? YELLOW : RED);
                push(r + k, mk(dir, lt, 1'b0), "rot_phase");
            end
        end
        step(115);

        // Gap-out: N drops after 1 s with S waiting.
        do_reset(4'b0101, 4'b0000, "reset_gap");
        for (int k = 1; k <= 40; k++) begin
            if (k < 4)       push(r + k, mk(2'd0, RED, 1'b0), "gap_allred0");
            else if (k < 12) push(r + k, mk(2'd0, GREEN, 1'b0), "gap_n_green");
            else if (k < 16) push(r + k, mk(2'd0, YELLOW, 1'b0), "gap_n_yellow");
            else if (k < 20) push(r + k, mk(2'd0, RED, 1'b0), "gap_allred1");
            else             push(r + k, mk(2'd2, GREEN, 1'b0), "gap_s_green");
        end
        step(8);
        bus.req = 4'b0100;
        step(32);

        // Emergency preemption of N, lowest-index tie-break to E, then W after E releases.
        do_reset(4'b0001, 4'b0000, "reset_emg");
        for (int k = 1; k <= 55; k++) begin
            if (k < 4)       push(r + k, mk(2'd0, RED, 1'b0), "emg_allred0");
            else if (k < 7)  push(r + k, mk(2'd0, GREEN, 1'b0), "emg_n_green");
            else if (k < 11) push(r + k, mk(2'd0, YELLOW, 1'b0), "emg_n_yellow");
            else if (k < 15) push(r + k, mk(2'd0, RED, 1'b0), "emg_allred1");
            else if (k < 41) push(r + k, mk(2'd1, GREEN, 1'b1), "emg_e_hold");
            else if (k < 45) push(r + k, mk(2'd1, YELLOW, 1'b1), "emg_e_yellow");
            else if (k < 49) push(r + k, mk(2'd1, RED, 1'b0), "emg_allred2");
            else             push(r + k, mk(2'd3, GREEN, 1'b1), "emg_w_green");
        end
        step(6);
        bus.emg_req = 4'b1010;
        step(34);
        bus.emg_req = 4'b1000;
        step(15);

        // Reset during S yellow, then the next grant restarts at N.
        do_reset(4'b0100, 4'b0000, "reset_mid_pre");
        for (int k = 1; k <= 21; k++) begin
            if (k < 4)       push(r + k, mk(2'd0, RED, 1'b0), "mid_allred");
            else if (k < 20) push(r + k, mk(2'd2, GREEN, 1'b0), "mid_s_green");
            else             push(r + k, mk(2'd2, YELLOW, 1'b0), "mid_s_yellow");
        end
        step(4);
        bus.req = 4'b0101;
        step(17);
        do_reset(4'b0101, 4'b0000, "reset_mid_async");
        for (int k = 1; k <= 10; k++) begin
            if (k < 4) push(r + k, mk(2'd0, RED, 1'b0), "post_allred");
            else       push(r + k, mk(2'd0, GREEN, 1'b0), "post_n_green");
        end
        step(10);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
